vp_filter: RTL and testbench
============================

VP_FILTER -- requirements
Module: vp_filter

Interface
REQ-001 SHALL have parameter DW, default 8, meaning pixel data width in bits.
REQ-002 SHALL have parameter RL, default 640, meaning number of windows per image row.
REQ-003 SHALL have port i_clk  input  1  system clock; the block uses one clock, all logic on its rising edge.
REQ-004 SHALL have port i_rstn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port i_pixel_data  input  9*DW  3x3 window.
  - Packing: p0 (top-left) in the MSBs through p8 (bottom-right) in the LSBs.
  - Row order: top row {p0,p1,p2}, middle row {p3,p4,p5}, bottom row {p6,p7,p8}; p4 is the center pixel.
REQ-006 SHALL have port i_pixel_valid  input  1  window qualifier; no backpressure.
REQ-007 SHALL have port i_mode  input  2  kernel select: 0 passthrough, 1 Gaussian, 2 Sobel, 3 sharpen.
REQ-008 SHALL have port o_pixel_data  output  DW  filtered pixel.
REQ-009 SHALL have port o_pixel_valid  output  1  qualifier for o_pixel_data.
REQ-010 SHALL have port o_eol  output  1  high with the last output pixel of each row.

Function
REQ-011 SHALL be a 3-stage pipeline:
  - S1 latches the window, valid and the active mode.
  - S2 forms signed products and partial sums.
  - S3 forms the final sum, normalizes and clamps.
REQ-012 SHALL assert o_pixel_valid exactly 3 cycles after each i_pixel_valid beat, with no bubbles added or removed.
REQ-013 SHALL leave o_pixel_data holding its last value when o_pixel_valid is low.
REQ-014 SHALL keep a column counter 0..RL-1 that increments on each input valid beat and wraps from RL-1 to 0.
REQ-015 SHALL sample i_mode only on a valid beat at column 0, and hold that mode for the full row; mid-row changes of i_mode are ignored.
REQ-016 SHALL delay the column-RL-1 marker through the pipeline so that o_eol coincides with that beat's o_pixel_valid.
REQ-017 Mode 0 SHALL output p4.
REQ-018 Mode 1 SHALL output (p0+2p1+p2+2p3+4p4+2p5+p6+2p7+p8)>>4 (truncating).
  - Accumulator at least DW+4 bits; no clamp needed.
REQ-019 Mode 2 SHALL output min(|Gx|+|Gy|, 2^DW-1).
  - Gx = (p2+2p5+p8)-(p0+2p3+p6).
  - Gy = (p6+2p7+p8)-(p0+2p1+p2).
  - Signed arithmetic, at least DW+4 bits.
REQ-020 Mode 3 SHALL output 5p4-(p1+p3+p5+p7), clamped: negative to 0, above 2^DW-1 to 2^DW-1.
REQ-021 SHALL never wrap arithmetically; every intermediate is wide enough for the worst-case inputs.
REQ-022 Back-to-back valid beats at full rate SHALL each produce one output.
REQ-023 A valid beat coinciding with the column wrap SHALL both emit o_eol (for beat RL-1) and sample i_mode (for the next beat at column 0) correctly.

Reset
REQ-024 Asserting i_rstn low SHALL asynchronously clear:
  - o_pixel_valid, o_eol and o_pixel_data to 0;
  - the column counter to 0;
  - all pipeline valid flags to 0;
  - the active mode to 0.
REQ-025 Reset mid-row SHALL discard in-flight beats; the first valid beat after release is column 0.
REQ-026 SHALL produce no output valid in the first cycle after reset release unless an input valid arrived 3 cycles earlier.

Configuration
REQ-027 Macro VP_FILTER_SOBEL_EN SHALL control mode 2.
  - Defined: mode 2 computes Sobel per REQ-019.
  - Undefined: no Sobel logic is synthesized and mode 2 behaves exactly as mode 0 (outputs p4).
  - Latency and o_eol timing are identical in both builds.

Verification
REQ-028 Mode 0, all window pixels 0x00 except p4=0xA5, one valid beat -> o_pixel_data=0xA5 with o_pixel_valid exactly 3 cycles later.
REQ-029 Mode 1, all pixels 0xFF, continuous valid -> every output 0xFF, no gaps, o_eol on output RL (640).
REQ-030 Mode 2 (macro defined), left column 0x00, right column 0xFF -> |Gx|=1020, output clamped to 0xFF; same stimulus with macro undefined -> output equals p4.
REQ-031 Mode 3, p4=0x00 with neighbors 0xFF -> 0x00; p4=0xFF with neighbors 0x00 -> 0xFF.
REQ-032 i_mode changed 0->1 at column 100 -> columns 100..639 still use mode 0; column 0 of the next row uses mode 1.
REQ-033 i_rstn pulsed low at column 300 with 3 beats in flight -> outputs 0 immediately, no stale valid after release, next row counted from column 0.

Source files
------------

// File: rtl/vp_filter.sv
// 3x3 window filter: passthrough, Gaussian, Sobel magnitude and sharpen, 3-stage pipeline.
// Optional build macro VP_FILTER_SOBEL_EN enables the Sobel kernel; without it mode 2 passes p4.
module vp_filter #(
    parameter int unsigned DW = 8,
    parameter int unsigned RL = 640
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic [9*DW-1:0]   i_pixel_data,
    input  logic              i_pixel_valid,
    input  logic [1:0]        i_mode,
    output logic [DW-1:0]     o_pixel_data,
    output logic              o_pixel_valid,
    output logic              o_eol
);

    localparam int unsigned CW = (RL > 1) ? $clog2(RL) : 1;
    localparam int unsigned AW = DW + 4;
    localparam logic [AW-1:0] PIX_MAX = {4'b0000, {DW{1'b1}}};
    localparam logic [1:0] MODE_GAUSS   = 2'd1;
    localparam logic [1:0] MODE_SOBEL   = 2'd2;
    localparam logic [1:0] MODE_SHARPEN = 2'd3;

    // ---------------- S1: column tracking, row mode, window latch
    logic [CW-1:0]   r_col;
    logic [1:0]      r_mode_act;
    logic [9*DW-1:0] r_s1_win;
    logic            r_s1_vld;
    logic            r_s1_eol;
    logic [1:0]      r_s1_mode;
    logic            w_col_first;
    logic            w_col_last;
    logic [1:0]      w_mode;

    assign w_col_first = (r_col == '0);
    assign w_col_last  = (r_col == CW'(RL - 1));
    // The column-0 beat itself already uses the freshly sampled mode.
    assign w_mode      = w_col_first ? i_mode : r_mode_act;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_col      <= '0;
            r_mode_act <= '0;
            r_s1_win   <= '0;
            r_s1_vld   <= 1'b0;
            r_s1_eol   <= 1'b0;
            r_s1_mode  <= '0;
        end else begin
            r_s1_vld <= i_pixel_valid;
            r_s1_eol <= i_pixel_valid && w_col_last;
            if (i_pixel_valid) begin
                r_s1_win  <= i_pixel_data;
                r_s1_mode <= w_mode;
                r_col     <= w_col_last ? '0 : r_col + CW'(1);
                if (w_col_first) begin
                    r_mode_act <= i_mode;
                end
            end
        end
    end

    // ---------------- S2: zero-extended pixels, weighted partial sums
    logic [AW-1:0] w_e [9];

    for (genvar gi = 0; gi < 9; gi++) begin : g_unpack
        assign w_e[gi] = AW'(r_s1_win[(8-gi)*DW +: DW]);
    end

    logic            r_s2_vld;
    logic            r_s2_eol;
    logic [1:0]      r_s2_mode;
    logic [DW-1:0]   r_s2_p4;
    logic [AW-1:0]   r_s2_g_top;
    logic [AW-1:0]   r_s2_g_mid;
    logic [AW-1:0]   r_s2_g_bot;
    logic [AW-1:0]   r_s2_sh_pos;
    logic [AW-1:0]   r_s2_sh_neg;
`ifdef VP_FILTER_SOBEL_EN
    logic signed [AW-1:0] r_s2_gx;
    logic signed [AW-1:0] r_s2_gy;
`endif

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_s2_vld    <= 1'b0;
            r_s2_eol    <= 1'b0;
            r_s2_mode   <= '0;
            r_s2_p4     <= '0;
            r_s2_g_top  <= '0;
            r_s2_g_mid  <= '0;
            r_s2_g_bot  <= '0;
            r_s2_sh_pos <= '0;
            r_s2_sh_neg <= '0;
`ifdef VP_FILTER_SOBEL_EN
            r_s2_gx     <= '0;
            r_s2_gy     <= '0;
`endif
        end else begin
            r_s2_vld <= r_s1_vld;
            r_s2_eol <= r_s1_eol;
            if (r_s1_vld) begin
                r_s2_mode   <= r_s1_mode;
                r_s2_p4     <= DW'(w_e[4]);
                r_s2_g_top  <= w_e[0] + (w_e[1] << 1) + w_e[2];
                r_s2_g_mid  <= (w_e[3] << 1) + (w_e[4] << 2) + (w_e[5] << 1);
                r_s2_g_bot  <= w_e[6] + (w_e[7] << 1) + w_e[8];
                r_s2_sh_pos <= (w_e[4] << 2) + w_e[4];
                r_s2_sh_neg <= w_e[1] + w_e[3] + w_e[5] + w_e[7];
`ifdef VP_FILTER_SOBEL_EN
                // Operands stay below 2^(DW+2), so the sign bit of AW is free.
                r_s2_gx <= $signed(w_e[2] + (w_e[5] << 1) + w_e[8])
                         - $signed(w_e[0] + (w_e[3] << 1) + w_e[6]);
                r_s2_gy <= $signed(w_e[6] + (w_e[7] << 1) + w_e[8])
                         - $signed(w_e[0] + (w_e[1] << 1) + w_e[2]);
`endif
            end
        end
    end

    // ---------------- S3: final sums, normalize, clamp, select
    logic [AW-1:0]        w_g_sum;
    logic signed [AW-1:0] w_sh;
    logic [DW-1:0]        w_sh_res;
    logic [DW-1:0]        w_res;
`ifdef VP_FILTER_SOBEL_EN
    logic [AW-1:0]        w_ax;
    logic [AW-1:0]        w_ay;
    logic [AW-1:0]        w_sob;
    logic [DW-1:0]        w_sob_res;
`endif

    always_comb begin
        w_g_sum  = r_s2_g_top + r_s2_g_mid + r_s2_g_bot;
        w_sh     = $signed(r_s2_sh_pos) - $signed(r_s2_sh_neg);
        w_sh_res = DW'(w_sh);
        if (w_sh < 0) begin
            w_sh_res = '0;
        end else if (w_sh > $signed(PIX_MAX)) begin
            w_sh_res = '1;
        end
`ifdef VP_FILTER_SOBEL_EN
        w_ax      = r_s2_gx[AW-1] ? AW'(-r_s2_gx) : AW'(r_s2_gx);
        w_ay      = r_s2_gy[AW-1] ? AW'(-r_s2_gy) : AW'(r_s2_gy);
        w_sob     = w_ax + w_ay;
        w_sob_res = (w_sob > PIX_MAX) ? '1 : DW'(w_sob);
`endif
        case (r_s2_mode)
            MODE_GAUSS:   w_res = DW'(w_g_sum >> 4);
`ifdef VP_FILTER_SOBEL_EN
            MODE_SOBEL:   w_res = w_sob_res;
`else
            MODE_SOBEL:   w_res = r_s2_p4;
`endif
            MODE_SHARPEN: w_res = w_sh_res;
            default:      w_res = r_s2_p4;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            o_pixel_valid <= 1'b0;
            o_eol         <= 1'b0;
            o_pixel_data  <= '0;
        end else begin
            o_pixel_valid <= r_s2_vld;
            o_eol         <= r_s2_eol;
            if (r_s2_vld) begin
                o_pixel_data <= w_res;
            end
        end
    end

endmodule

// File: tb/tb_vp_filter.sv
// Randomized self-checking bench for vp_filter against a per-beat arithmetic reference model.
module tb_vp_filter;

    localparam int unsigned DW   = 8;
    localparam int unsigned RL   = 640;
    localparam int          MAXV = (1 << DW) - 1;

    logic              clk;
    logic              rstn;
    logic [9*DW-1:0]   i_pixel_data;
    logic              i_pixel_valid;
    logic [1:0]        i_mode;
    logic [DW-1:0]     o_pixel_data;
    logic              o_pixel_valid;
    logic              o_eol;

    vp_filter #(.DW(DW), .RL(RL)) dut (
        .i_clk         (clk),
        .i_rstn        (rstn),
        .i_pixel_data  (i_pixel_data),
        .i_pixel_valid (i_pixel_valid),
        .i_mode        (i_mode),
        .o_pixel_data  (o_pixel_data),
        .o_pixel_valid (o_pixel_valid),
        .o_eol         (o_eol)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int            due;
        logic [DW-1:0] d;
        logic          eol;
    } exp_t;

    exp_t          exp_q[$];
    int            cyc = 0;
    int            n_tests = 0;
    int            n_fail = 0;
    int            m_col = 0;
    int            m_mode = 0;
    logic [DW-1:0] last_d = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] ref_pix(input int p[9], input int m);
        int v;
        int gx;
        int gy;
        case (m)
            1: v = (p[0] + 2*p[1] + p[2] + 2*p[3] + 4*p[4] + 2*p[5] + p[6] + 2*p[7] + p[8]) / 16;
            2: begin
`ifdef VP_FILTER_SOBEL_EN
                gx = (p[2] + 2*p[5] + p[8]) - (p[0] + 2*p[3] + p[6]);
                gy = (p[6] + 2*p[7] + p[8]) - (p[0] + 2*p[1] + p[2]);
                v  = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
                if (v > MAXV) v = MAXV;
`else
                gx = 0;
                gy = 0;
                v  = p[4] + gx + gy;
`endif
            end
            3: begin
                v = 5*p[4] - (p[1] + p[3] + p[5] + p[7]);
                if (v < 0) v = 0;
                if (v > MAXV) v = MAXV;
            end
            default: v = p[4];
        endcase
        return DW'(v);
    endfunction

    // Expected output timeline: each accepted beat becomes due three cycles later.
    always @(negedge clk) begin
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            check("valid", 32'(o_pixel_valid), 32'(1));
            check("data", 32'(o_pixel_data), 32'(exp_q[0].d));
            check("eol", 32'(o_eol), 32'(exp_q[0].eol));
            last_d = exp_q[0].d;
            void'(exp_q.pop_front());
        end else begin
            check("idle_valid", 32'(o_pixel_valid), 32'(0));
            check("idle_eol", 32'(o_eol), 32'(0));
            check("hold", 32'(o_pixel_data), 32'(last_d));
        end
    end

    task automatic drive(input bit v, input int p[9], input logic [1:0] m);
        logic [9*DW-1:0] pk;
        exp_t e;
        pk = '0;
        for (int i = 0; i < 9; i++) pk = (pk << DW) | (9*DW)'(p[i]);
        i_pixel_data  = pk;
        i_pixel_valid = v;
        i_mode        = m;
        if (v) begin
            if (m_col == 0) m_mode = int'(m);
            e.due = cyc + 3;
            e.d   = ref_pix(p, m_mode);
            e.eol = (m_col == RL - 1);
            exp_q.push_back(e);
            m_col = (m_col == RL - 1) ? 0 : m_col + 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        int z[9];
        for (int i = 0; i < 9; i++) z[i] = 0;
        for (int i = 0; i < n; i++) drive(1'b0, z, 2'd0);
    endtask

    task automatic do_reset();
        rstn          = 1'b0;
        i_pixel_valid = 1'b0;
        exp_q.delete();
        m_col  = 0;
        m_mode = 0;
        last_d = '0;
        #1;
        check("rst_valid", 32'(o_pixel_valid), 32'(0));
        check("rst_eol", 32'(o_eol), 32'(0));
        check("rst_data", 32'(o_pixel_data), 32'(0));
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    function automatic int rpix();
        int r;
        r = int'($urandom_range(0, 7));
        if (r == 0) return 0;
        if (r == 1) return MAXV;
        return int'($urandom_range(0, MAXV));
    endfunction

    task automatic rand_win(output int p[9]);
        for (int i = 0; i < 9; i++) p[i] = rpix();
    endtask

    initial begin
        int w[9];
        rstn          = 1'b0;
        i_pixel_valid = 1'b0;
        i_pixel_data  = '0;
        i_mode        = 2'd0;
        #2;
        do_reset();
        idle(2);

        // Single passthrough beat, p4 only
        for (int i = 0; i < 9; i++) w[i] = 0;
        w[4] = 'hA5;
        drive(1'b1, w, 2'd0);
        idle(5);

        // Full row of saturated pixels through Gaussian, continuous valid
        do_reset();
        for (int i = 0; i < 9; i++) w[i] = MAXV;
        for (int i = 0; i < RL; i++) drive(1'b1, w, 2'd1);
        idle(4);

        // Vertical edge: left column 0, right column max
        do_reset();
        w = '{0, 'h80, MAXV, 0, 'h80, MAXV, 0, 'h80, MAXV};
        drive(1'b1, w, 2'd2);
        idle(4);

        // Sharpen extremes
        do_reset();
        for (int i = 0; i < 9; i++) w[i] = MAXV;
        w[4] = 0;
        drive(1'b1, w, 2'd3);
        for (int i = 0; i < 9; i++) w[i] = 0;
        w[4] = MAXV;
        drive(1'b1, w, 2'd3);
        idle(4);

        // Mode change mid-row only takes effect at the next row
        do_reset();
        for (int c = 0; c < RL + 20; c++) begin
            rand_win(w);
            drive(1'b1, w, (c < 100) ? 2'd0 : 2'd1);
        end
        idle(4);

        // Reset mid-row with beats in flight
        do_reset();
        for (int c = 0; c <= 300; c++) begin
            rand_win(w);
            drive(1'b1, w, 2'd3);
        end
        do_reset();
        idle(4);
        for (int c = 0; c < 10; c++) begin
            rand_win(w);
            drive(1'b1, w, 2'd1);
        end
        idle(4);

        // Random windows, modes and valid gaps across several rows
        do_reset();
        for (int n = 0; n < 4 * RL; n++) begin
            rand_win(w);
            drive(($urandom_range(0, 3) != 0), w, 2'($urandom_range(0, 3)));
        end
        idle(6);
        check("drain", 32'(exp_q.size()), 32'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
